// File: rtl/fetch_controller.sv
// fetch_controller
//   Sequences instruction fetch around the program counter. Issues PC addresses to
//   instruction memory over a req/ready + rvalid handshake with at most one request
//   outstanding, hands each fetched instruction to decode over valid/ready, and applies
//   branch/jump redirects while discarding stale responses.
//
//   Optional feature macro: FETCH_TIMEOUT_EN
//     defined   - WAIT-state cycle counter; after TIMEOUT_CYCLES without a response
//                 fetch_err is set (sticky until start/reset) and the FSM returns to IDLE.
//     undefined - no counter, fetch_err tied low, WAIT waits indefinitely.
//
// Ports
//   clock, reset_n            clock (rising edge), asynchronous active-low reset
//   start                     pulse in IDLE: begin fetching from fetch_pc
//   redirect_valid/_pc        redirect request and target (bits [1:0] ignored)
//   imem_req/_addr            fetch request and address to instruction memory
//   imem_ready                request accepted when imem_req && imem_ready
//   imem_rvalid/_rdata        response valid and instruction
//   inst_valid/_data/_pc      instruction presented to decode
//   inst_ready                decode consumes when inst_valid && inst_ready
//   fetch_pc                  next PC to be requested
//   fetch_err                 sticky fetch timeout flag
module fetch_controller #(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned INST_W         = 32,
`ifdef FETCH_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 255,
`endif
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_data,
  output logic [XLEN-1:0]   inst_pc,
  input  logic              inst_ready,
  output logic [XLEN-1:0]   fetch_pc,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_HOLD
  } state_t;

  localparam logic [XLEN-1:0] PC_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  state_t              state_q;
  logic [XLEN-1:0]     fetch_pc_q;
  logic [XLEN-1:0]     req_pc_q;
  logic [XLEN-1:0]     inst_pc_q;
  logic [INST_W-1:0]   inst_data_q;
  logic                inst_valid_q;
  logic                drop_q;
  logic [XLEN-1:0]     redir_pc_d;
  logic [XLEN-1:0]     pc_plus4_d;

  assign redir_pc_d = redirect_pc & PC_MASK;
  assign pc_plus4_d = fetch_pc_q + XLEN'(4);

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt_q;
  logic             fetch_err_q;
  logic             timeout_d;

  // Fires on the TIMEOUT_CYCLES-th consecutive WAIT cycle without a response.
  assign timeout_d = (state_q == ST_WAIT) && !imem_rvalid &&
                     (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign fetch_err = fetch_err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q    <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      if (state_q == ST_WAIT && !imem_rvalid && !timeout_d) begin
        to_cnt_q <= to_cnt_q + CNT_W'(1);
      end else begin
        to_cnt_q <= '0;
      end
      if (timeout_d) begin
        fetch_err_q <= 1'b1;
      end else if (state_q == ST_IDLE && start) begin
        fetch_err_q <= 1'b0;
      end
    end
  end
`else
  assign fetch_err = 1'b0;
`endif

  assign imem_req   = (state_q == ST_FETCH);
  assign imem_addr  = fetch_pc_q;
  assign fetch_pc   = fetch_pc_q;
  assign inst_valid = inst_valid_q;
  assign inst_data  = inst_data_q;
  assign inst_pc    = inst_pc_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= '0;
      inst_pc_q    <= '0;
      inst_data_q  <= '0;
      inst_valid_q <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (redirect_valid) begin
            fetch_pc_q <= redir_pc_d;
          end
          if (start) begin
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (imem_ready) begin
            req_pc_q <= fetch_pc_q;
            // A redirect in the acceptance cycle makes the just-issued request stale.
            drop_q   <= redirect_valid;
            state_q  <= ST_WAIT;
          end
          if (redirect_valid) begin
            fetch_pc_q <= redir_pc_d;
          end else if (imem_ready) begin
            fetch_pc_q <= pc_plus4_d;
          end
        end
        ST_WAIT: begin
          if (redirect_valid) begin
            fetch_pc_q <= redir_pc_d;
          end
`ifdef FETCH_TIMEOUT_EN
          if (timeout_d) begin
            drop_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else
`endif
          if (imem_rvalid) begin
            drop_q <= 1'b0;
            if (drop_q || redirect_valid) begin
              state_q <= ST_FETCH;
            end else begin
              inst_data_q  <= imem_rdata;
              inst_pc_q    <= req_pc_q;
              inst_valid_q <= 1'b1;
              state_q      <= ST_HOLD;
            end
          end else if (redirect_valid) begin
            drop_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (redirect_valid) begin
            fetch_pc_q <= redir_pc_d;
          end
          if (redirect_valid || inst_ready) begin
            inst_valid_q <= 1'b0;
            state_q      <= ST_FETCH;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;
  logic        inst_ready;
  logic [63:0] fetch_pc;
  logic        fetch_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  fetch_controller #(
    .XLEN     (64),
    .INST_W   (32),
    .RESET_PC (64'h0)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .fetch_pc       (fetch_pc),
    .fetch_err      (fetch_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        start;
    logic        rv;
    logic [63:0] rpc;
    logic        rdy;
    logic        rvalid;
    logic [31:0] rdata;
    logic        iready;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_iv;
    logic [31:0] e_data;
    logic [63:0] e_pc;
    logic [63:0] e_fpc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic rv, input logic [63:0] rpc, input logic rdy,
                     input logic rvalid, input logic [31:0] rdata, input logic iready,
                     input logic e_req, input logic [63:0] e_addr, input logic e_iv,
                     input logic [31:0] e_data, input logic [63:0] e_pc, input logic [63:0] e_fpc);
    vec_t v;
    v.start = st; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.rvalid = rvalid; v.rdata = rdata;
    v.iready = iready; v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_data = e_data;
    v.e_pc = e_pc; v.e_fpc = e_fpc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic req, input logic [63:0] addr,
                            input logic iv, input logic [31:0] d, input logic [63:0] pc,
                            input logic [63:0] fpc);
    chk({tag, ".imem_req"}, {63'b0, imem_req}, {63'b0, req});
    if (req) chk({tag, ".imem_addr"}, imem_addr, addr);
    chk({tag, ".inst_valid"}, {63'b0, inst_valid}, {63'b0, iv});
    if (iv) begin
      chk({tag, ".inst_data"}, {32'b0, inst_data}, {32'b0, d});
      chk({tag, ".inst_pc"}, inst_pc, pc);
    end
    chk({tag, ".fetch_pc"}, fetch_pc, fpc);
    chk({tag, ".fetch_err"}, {63'b0, fetch_err}, 64'h0);
  endtask

  task automatic clear_inputs();
    start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Transaction-level reference: next PC, the single outstanding request and the held instruction.
  logic [63:0] m_pc;
  logic        m_out;
  logic [63:0] m_oaddr;
  logic        m_odrop;
  int unsigned m_odelay;
  logic        m_iv;
  logic [31:0] m_idata;
  logic [63:0] m_ipc;

  function automatic logic m_req();
    return !m_out && !m_iv;
  endfunction

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset.inst_data", {32'b0, inst_data}, 64'h0);
    chk("reset.inst_pc", inst_pc, 64'h0);
    check_outs("reset", 1'b0, 64'h0, 1'b0, 32'h0, 64'h0, 64'h0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;

    //   st rv rpc                    rdy rvl rdata        ird | req addr               iv data         pc                   fpc
    add(1, 0, 64'h0,                  0, 0, 32'h0,        0,   1, 64'h0,              0, 32'h0,        64'h0,               64'h0);
    add(0, 0, 64'h0,                  1, 0, 32'h0,        0,   0, 64'h0,              0, 32'h0,        64'h0,               64'h4);
    add(0, 0, 64'h0,                  0, 0, 32'h0,        0,   0, 64'h0,              0, 32'h0,        64'h0,               64'h4);
    add(0, 0, 64'h0,                  0, 1, 32'h00500093, 0,   0, 64'h0,              1, 32'h00500093, 64'h0,               64'h4);
    add(0, 0, 64'h0,                  0, 0, 32'h0,        1,   1, 64'h4,              0, 32'h0,        64'h0,               64'h4);
    add(0, 0, 64'h0,                  1, 0, 32'h0,        0,   0, 64'h0,              0, 32'h0,        64'h0,               64'h8);
    add(0, 0, 64'h0,                  0, 1, 32'h00A00113, 0,   0, 64'h0,              1, 32'h00A00113, 64'h4,               64'h8);
    for (int i = 0; i < 5; i++)
      add(0, 0, 64'h0,                0, 0, 32'h0,        0,   0, 64'h0,              1, 32'h00A00113, 64'h4,               64'h8);
    add(0, 0, 64'h0,                  0, 0, 32'h0,        1,   1, 64'h8,              0, 32'h0,        64'h0,               64'h8);
    add(0, 0, 64'h0,                  1, 0, 32'h0,        0,   0, 64'h0,              0, 32'h0,        64'h0,               64'hC);
    add(0, 1, 64'h103,                0, 0, 32'h0,        0,   0, 64'h0,              0, 32'h0,        64'h0,               64'h100);
    add(0, 0, 64'h0,                  0, 1, 32'hDEADBEEF, 0,   1, 64'h100,            0, 32'h0,        64'h0,               64'h100);
    for (int i = 0; i < 3; i++)
      add(0, 0, 64'h0,                0, 0, 32'h0,        0,   1, 64'h100,            0, 32'h0,        64'h0,               64'h100);
    add(0, 1, 64'h200,                0, 0, 32'h0,        0,   1, 64'h200,            0, 32'h0,        64'h0,               64'h200);
    add(0, 0, 64'h0,                  1, 0, 32'h0,        0,   0, 64'h0,              0, 32'h0,        64'h0,               64'h204);
    add(0, 0, 64'h0,                  0, 1, 32'h11111111, 0,   0, 64'h0,              1, 32'h11111111, 64'h200,             64'h204);
    add(0, 1, 64'h300,                0, 0, 32'h0,        1,   1, 64'h300,            0, 32'h0,        64'h0,               64'h300);
    add(0, 1, 64'h400,                1, 0, 32'h0,        0,   0, 64'h0,              0, 32'h0,        64'h0,               64'h400);
    add(0, 0, 64'h0,                  0, 1, 32'h44444444, 0,   1, 64'h400,            0, 32'h0,        64'h0,               64'h400);
    add(0, 0, 64'h0,                  1, 0, 32'h0,        0,   0, 64'h0,              0, 32'h0,        64'h0,               64'h404);
    add(0, 1, 64'h502,                0, 1, 32'h55555555, 0,   1, 64'h500,            0, 32'h0,        64'h0,               64'h500);
    add(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 32'h0,       0,   1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'h0,   64'h0,               64'hFFFF_FFFF_FFFF_FFFC);
    add(0, 0, 64'h0,                  1, 0, 32'h0,        0,   0, 64'h0,              0, 32'h0,        64'h0,               64'h0);
    add(0, 0, 64'h0,                  0, 1, 32'h22222222, 0,   0, 64'h0,              1, 32'h22222222, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
    add(0, 0, 64'h0,                  0, 0, 32'h0,        1,   1, 64'h0,              0, 32'h0,        64'h0,               64'h0);
    add(0, 0, 64'h0,                  0, 1, 32'h33333333, 0,   1, 64'h0,              0, 32'h0,        64'h0,               64'h0);
    add(0, 0, 64'h0,                  1, 0, 32'h0,        0,   0, 64'h0,              0, 32'h0,        64'h0,               64'h4);
    add(0, 0, 64'h0,                  0, 1, 32'h66666666, 0,   0, 64'h0,              1, 32'h66666666, 64'h0,               64'h4);
    add(0, 1, 64'h600,                0, 0, 32'h0,        0,   1, 64'h600,            0, 32'h0,        64'h0,               64'h600);
    add(0, 0, 64'h0,                  1, 0, 32'h0,        0,   0, 64'h0,              0, 32'h0,        64'h0,               64'h604);
    add(0, 0, 64'h0,                  0, 1, 32'h77777777, 0,   0, 64'h0,              1, 32'h77777777, 64'h600,             64'h604);
    add(0, 0, 64'h0,                  0, 1, 32'h88888888, 0,   0, 64'h0,              1, 32'h77777777, 64'h600,             64'h604);
    add(0, 0, 64'h0,                  0, 0, 32'h0,        1,   1, 64'h604,            0, 32'h0,        64'h0,               64'h604);

    foreach (vecs[i]) begin
      start = vecs[i].start; redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
      imem_ready = vecs[i].rdy; imem_rvalid = vecs[i].rvalid; imem_rdata = vecs[i].rdata;
      inst_ready = vecs[i].iready;
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_iv,
                 vecs[i].e_data, vecs[i].e_pc, vecs[i].e_fpc);
    end
    clear_inputs();

    // Reset mid-transaction, then a late response in IDLE must be ignored.
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_outs("async_reset", 1'b0, 64'h0, 1'b0, 32'h0, 64'h0, 64'h0);
    @(negedge clock);
    reset_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hCAFEF00D;
    tick();
    check_outs("idle_rvalid", 1'b0, 64'h0, 1'b0, 32'h0, 64'h0, 64'h0);
    clear_inputs();
    redirect_valid = 1'b1; redirect_pc = 64'h77;
    tick();
    check_outs("idle_redirect", 1'b0, 64'h0, 1'b0, 32'h0, 64'h0, 64'h74);
    clear_inputs();
    start = 1'b1;
    tick();
    check_outs("restart", 1'b1, 64'h74, 1'b0, 32'h0, 64'h0, 64'h74);
    clear_inputs();
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    check_outs("long_wait_enter", 1'b0, 64'h0, 1'b0, 32'h0, 64'h0, 64'h78);
`ifdef FETCH_TIMEOUT_EN
    repeat (254) tick();
    chk("timeout.before_err", {63'b0, fetch_err}, 64'h0);
    chk("timeout.before_req", {63'b0, imem_req}, 64'h0);
    tick();
    chk("timeout.err_set", {63'b0, fetch_err}, 64'h1);
    chk("timeout.req", {63'b0, imem_req}, 64'h0);
    chk("timeout.iv", {63'b0, inst_valid}, 64'h0);
    repeat (3) tick();
    chk("timeout.idle_req", {63'b0, imem_req}, 64'h0);
    chk("timeout.sticky", {63'b0, fetch_err}, 64'h1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_outs("timeout.resume", 1'b1, 64'h78, 1'b0, 32'h0, 64'h0, 64'h78);
`else
    repeat (300) tick();
    check_outs("long_wait", 1'b0, 64'h0, 1'b0, 32'h0, 64'h0, 64'h78);
    imem_rvalid = 1'b1; imem_rdata = 32'h12345678;
    tick();
    clear_inputs();
    check_outs("long_wait_resp", 1'b0, 64'h0, 1'b1, 32'h12345678, 64'h74, 64'h78);
    inst_ready = 1'b1;
    tick();
    clear_inputs();
    check_outs("long_wait_next", 1'b1, 64'h78, 1'b0, 32'h0, 64'h0, 64'h78);
`endif

    // Randomized run against the transaction-level reference.
    clear_inputs();
    reset_n = 1'b0;
    tick();
    @(negedge clock);
    reset_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    m_pc = 64'h0; m_out = 1'b0; m_oaddr = '0; m_odrop = 1'b0; m_odelay = 0;
    m_iv = 1'b0; m_idata = '0; m_ipc = '0;
    check_outs("rand_start", m_req(), m_pc, m_iv, m_idata, m_ipc, m_pc);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        acc;
      logic        n_out;
      logic        n_iv;
      redirect_valid = ($urandom_range(9) == 0);
      if ($urandom_range(3) == 0)
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
      else
        redirect_pc = {32'($urandom), 32'($urandom)};
      imem_ready = ($urandom_range(2) != 0);
      inst_ready = ($urandom_range(2) != 0);
      imem_rdata = 32'($urandom);
      imem_rvalid = m_out ? (m_odelay == 0) : ($urandom_range(7) == 0);

      acc   = m_req() && imem_ready;
      n_out = m_out;
      n_iv  = m_iv;
      if (m_iv && (redirect_valid || inst_ready)) n_iv = 1'b0;
      if (acc) begin
        n_out    = 1'b1;
        m_oaddr  = m_pc;
        m_odrop  = redirect_valid;
        m_odelay = $urandom_range(3);
      end else if (m_out) begin
        if (imem_rvalid) begin
          n_out = 1'b0;
          if (!(m_odrop || redirect_valid)) begin
            n_iv    = 1'b1;
            m_idata = imem_rdata;
            m_ipc   = m_oaddr;
          end
        end else begin
          if (redirect_valid) m_odrop = 1'b1;
          m_odelay--;
        end
      end
      if (redirect_valid) m_pc = redirect_pc & ~64'h3;
      else if (acc)       m_pc = m_pc + 64'h4;
      m_out = n_out;
      m_iv  = n_iv;

      tick();
      check_outs($sformatf("rand%0d", cyc), m_req(), m_pc, m_iv, m_idata, m_ipc, m_pc);
    end
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
